cms_axis_fifo: RTL and testbench
================================

# cms_axis_fifo

Buffers the 512-bit AXI-Stream trace output of the continuous monitoring system (CMS) before it reaches the DMA/AXI-Stream FIFO consumer. The CMS keeps producing while the DMA stalls briefly, and this block absorbs those stalls. It is a first-word-fall-through circular buffer with full/empty back-pressure, a synchronous flush, and a count of forwarded packets. It sits directly downstream of the CMS master port and directly upstream of the DMA S2MM stream input.

## Interface
Parameters:
- DATA_WIDTH, 512, tdata width; equals the CMS AXI data width.
- DEPTH, 16, number of entries; power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- S_AXIS_tdata  in  DATA_WIDTH  beat from CMS
- S_AXIS_tvalid  in  1  CMS beat valid
- S_AXIS_tlast  in  1  last beat of CMS packet
- S_AXIS_tready  out  1  buffer can accept a beat
- M_AXIS_tdata  out  DATA_WIDTH  head beat to DMA
- M_AXIS_tvalid  out  1  head beat valid
- M_AXIS_tlast  out  1  tlast of head beat
- M_AXIS_tready  in  1  DMA accepts beat
- flush  in  1  synchronous discard of all contents
- level  out  $clog2(DEPTH)+1  current occupancy
- pkt_count  out  32  packets forwarded (count of M-side handshakes with tlast=1)
- max_level  out  $clog2(DEPTH)+1  occupancy high-water mark

## Operation
- Storage: DEPTH entries of {tdata, tlast}. Write and read pointers are $clog2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
- Push: S_AXIS_tvalid && S_AXIS_tready. Writes the entry at wr_ptr, then wr_ptr+1.
- Pop: M_AXIS_tvalid && M_AXIS_tready. Advances rd_ptr.
- S_AXIS_tready = !(level == DEPTH) && !flush. It is registered-state derived only, with no combinational path from M_AXIS_tready. A pop at full therefore does not allow a push in the same cycle.
- M_AXIS_tvalid = (level != 0). M_AXIS_tdata/tlast come from the entry at rd_ptr and stay stable while tvalid=1 and tready=0.
- Simultaneous push and pop with 0<level<DEPTH: level is unchanged and both pointers advance.
- Pointer wrap: modulo 2·DEPTH. The index is the low $clog2(DEPTH) bits.
- flush: next cycle, both pointers and level are 0 and any push in the flush cycle is discarded. pkt_count is unaffected. max_level is cleared.
- pkt_count: +1 on each pop with tlast=1. It wraps from 2^32−1 to 0.
- Reset values: pointers 0, level 0, M_AXIS_tvalid 0, S_AXIS_tready 0 during rst and 1 on the first cycle after, pkt_count 0, max_level 0. M_AXIS_tdata/tlast are don't-care while tvalid=0.
- Reset mid-packet: contents are lost and no tlast is synthesised. The downstream DMA is reset alongside.

## Timing
- Latency: a beat pushed in cycle N is presented with M_AXIS_tvalid=1 in cycle N+1.
- Throughput: one beat per cycle sustained when 0<level<DEPTH.
- Full: the last push sets level=DEPTH, and S_AXIS_tready=0 from the next cycle until the cycle after the first pop.
- Empty: the last pop sets level=0, and M_AXIS_tvalid=0 from the next cycle.
- level and max_level are registered and reflect push/pop of the previous cycle.

## Configuration
- CMS_FIFO_STATS_EN defined: max_level is a register updated to level_next whenever level_next > max_level, and is cleared by rst or flush.
- CMS_FIFO_STATS_EN undefined: max_level is tied to 0 and no comparator or register is synthesised.
- All other behaviour is identical in both builds.

## Structure
- Shared package cms_pkg holds:
  - constant AXI_DATA_WIDTH = 512
  - typedef axis_beat_t {logic [AXI_DATA_WIDTH-1:0] tdata; logic tlast;}
  - the pkt_count width constant (32)
- One sub-module, cms_fifo_ram: DEPTH×axis_beat_t array with one synchronous write port and a combinational read at rd index, intended for distributed RAM. Pointer, level and statistics logic stay in cms_axis_fifo.

## Test plan
- Reset then 3 pushes (tdata 1,2,3; tlast on 3) with M_AXIS_tready=0 -> level=3, head tdata=1. Then tready=1 for 3 cycles -> outputs 1,2,3 in order, pkt_count=1, level=0.
- DEPTH=16: push 16 beats with tready=0 -> S_AXIS_tready=0 after the 16th, level=16. One pop -> tready=1 the following cycle, not the same cycle.
- Continuous push and pop at level 5 for 40 cycles (pointers wrap twice) -> level stays 5, data order preserved, no gaps.
- flush asserted at level 7 with a simultaneous push -> next cycle level=0, M_AXIS_tvalid=0, and the pushed beat never appears. pkt_count is unchanged.
- rst asserted mid-packet at level 4 -> next cycle all outputs at reset values. A new 2-beat packet afterwards is delivered intact.
- With CMS_FIFO_STATS_EN: fill to 9, drain to 0 -> max_level=9. After flush -> 0. Without the macro -> max_level=0 throughout.

Source files
------------

// File: rtl/cms_pkg.sv
// rtl/cms_pkg.sv - shared CMS stream types and constants
//
// Purpose : common definitions for the CMS trace path.
// Contents: AXI_DATA_WIDTH  - tdata width of the CMS master port
//           PKT_COUNT_WIDTH - width of forwarded-packet counters
//           axis_beat_t     - one stored stream beat {tdata, tlast}

package cms_pkg;

    localparam int AXI_DATA_WIDTH  = 512;
    localparam int PKT_COUNT_WIDTH = 32;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] tdata;
        logic                      tlast;
    } axis_beat_t;

endpackage

// File: rtl/cms_fifo_ram.sv
// rtl/cms_fifo_ram.sv - beat storage array for the CMS stream FIFO
//
// Purpose : DEPTH x axis_beat_t array, one synchronous write port and a
//           combinational read port (maps onto distributed RAM).
// Ports   : clk     - write clock
//           we      - write enable
//           wr_idx  - write index
//           wr_beat - beat written at wr_idx
//           rd_idx  - read index
//           rd_beat - beat currently stored at rd_idx

module cms_fifo_ram
    import cms_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_idx,
    input  axis_beat_t    wr_beat,
    input  logic [AW-1:0] rd_idx,
    output axis_beat_t    rd_beat
);

    axis_beat_t mem [DEPTH];

    // No reset: contents are only observable once level says they are valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_beat;
        end
    end

    assign rd_beat = mem[rd_idx];

endmodule

// File: rtl/cms_axis_fifo.sv
// rtl/cms_axis_fifo.sv - first-word-fall-through FIFO for the CMS trace stream
//
// Purpose : absorbs short DMA stalls between the CMS master port and the
//           DMA S2MM input. Full/empty back-pressure, synchronous flush,
//           forwarded-packet counter, optional occupancy high-water mark.
// Build   : CMS_FIFO_STATS_EN defined   -> max_level tracks peak occupancy
//           CMS_FIFO_STATS_EN undefined -> max_level tied to 0
// Ports   : clk, rst          - clock, synchronous active-high reset
//           S_AXIS_*          - upstream beat from CMS (tdata/tvalid/tlast/tready)
//           M_AXIS_*          - head beat to DMA (tdata/tvalid/tlast/tready)
//           flush             - discard all contents next cycle
//           level             - current occupancy
//           pkt_count         - M-side handshakes with tlast=1 (wraps)
//           max_level         - occupancy high-water mark

module cms_axis_fifo
    import cms_pkg::*;
#(
    parameter int DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      S_AXIS_tdata,
    input  logic                       S_AXIS_tvalid,
    input  logic                       S_AXIS_tlast,
    output logic                       S_AXIS_tready,
    output logic [DATA_WIDTH-1:0]      M_AXIS_tdata,
    output logic                       M_AXIS_tvalid,
    output logic                       M_AXIS_tlast,
    input  logic                       M_AXIS_tready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     level,
    output logic [PKT_COUNT_WIDTH-1:0] pkt_count,
    output logic [$clog2(DEPTH):0]     max_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] level_q;
    logic [PW-1:0] level_next;
    logic [PKT_COUNT_WIDTH-1:0] pkt_count_q;

    logic       full;
    logic       push;
    logic       pop;
    axis_beat_t wr_beat;
    axis_beat_t rd_beat;

    // Ready depends only on registered occupancy and the local controls, so a
    // pop at full cannot open the input in the same cycle.
    assign full          = (level_q == PW'(DEPTH));
    assign S_AXIS_tready = !full && !flush && !rst;
    assign M_AXIS_tvalid = (level_q != '0);

    assign push = S_AXIS_tvalid && S_AXIS_tready;
    assign pop  = M_AXIS_tvalid && M_AXIS_tready;

    assign wr_beat.tdata = AXI_DATA_WIDTH'(S_AXIS_tdata);
    assign wr_beat.tlast = S_AXIS_tlast;

    cms_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (push),
        .wr_idx  (wr_ptr[AW-1:0]),
        .wr_beat (wr_beat),
        .rd_idx  (rd_ptr[AW-1:0]),
        .rd_beat (rd_beat)
    );

    assign M_AXIS_tdata = DATA_WIDTH'(rd_beat.tdata);
    assign M_AXIS_tlast = rd_beat.tlast;

    always_comb begin
        level_next = level_q;
        if (flush) begin
            level_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   level_next = level_q + PW'(1);
                2'b01:   level_next = level_q - PW'(1);
                default: level_next = level_q;
            endcase
        end
    end

    // Pointers carry one extra MSB; they wrap modulo 2*DEPTH naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level_q <= level_next;
        end
    end

    // A handshake in a flush cycle still delivered the beat downstream, so it
    // is counted; flush itself never touches the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q <= '0;
        end else if (pop && rd_beat.tlast) begin
            pkt_count_q <= pkt_count_q + PKT_COUNT_WIDTH'(1);
        end
    end

    assign level     = level_q;
    assign pkt_count = pkt_count_q;

`ifdef CMS_FIFO_STATS_EN
    logic [PW-1:0] max_level_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            max_level_q <= '0;
        end else if (level_next > max_level_q) begin
            max_level_q <= level_next;
        end
    end

    assign max_level = max_level_q;
`else
    assign max_level = '0;
`endif

endmodule

// File: tb/tb_cms_axis_fifo.sv
// tb/tb_cms_axis_fifo.sv - scoreboard testbench for cms_axis_fifo

module tb_cms_axis_fifo;

    localparam int DW    = 512;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic          flush;
    logic [LW-1:0] level;
    logic [31:0]   pkt_count;
    logic [LW-1:0] max_level;

    cms_axis_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tvalid (s_tvalid),
        .S_AXIS_tlast  (s_tlast),
        .S_AXIS_tready (s_tready),
        .M_AXIS_tdata  (m_tdata),
        .M_AXIS_tvalid (m_tvalid),
        .M_AXIS_tlast  (m_tlast),
        .M_AXIS_tready (m_tready),
        .flush         (flush),
        .level         (level),
        .pkt_count     (pkt_count),
        .max_level     (max_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected stream contents as a plain queue.
    beat_t       exp_q[$];
    int unsigned m_pkt = 0;
    int          m_max = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    // Monitor: compares outputs against the model, then advances the model
    // using the handshakes that will occur at the coming rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            int    sz;
            bit    exp_srdy;
            bit    m_acc;
            bit    s_acc;
            beat_t b;
            sz       = exp_q.size();
            exp_srdy = !rst && !flush && (sz < DEPTH);
            check("s_tready", 64'(s_tready), 64'(exp_srdy));
            check("m_tvalid", 64'(m_tvalid), 64'(sz != 0));
            if (sz != 0) begin
                check_w("m_tdata", m_tdata, exp_q[0].d);
                check("m_tlast", 64'(m_tlast), 64'(exp_q[0].l));
            end
            check("level", 64'(level), 64'(sz));
            check("pkt_count", 64'(pkt_count), 64'(m_pkt));
            check("max_level", 64'(max_level), 64'(m_max));

            m_acc = (sz != 0) && m_tready;
            s_acc = s_tvalid && exp_srdy;
            if (rst) begin
                exp_q.delete();
                m_pkt = 0;
                m_max = 0;
            end else begin
                if (m_acc) begin
                    b = exp_q.pop_front();
                    if (b.l) m_pkt = m_pkt + 1;
                end
                if (flush) begin
                    exp_q.delete();
                    m_max = 0;
                end else begin
                    if (s_acc) exp_q.push_back('{d: s_tdata, l: s_tlast});
`ifdef CMS_FIFO_STATS_EN
                    if (exp_q.size() > m_max) m_max = exp_q.size();
`endif
                end
            end
        end
    end

    // Drive one cycle of inputs, then advance to just after the next edge.
    task automatic cyc(input bit sv, input logic [DW-1:0] d, input bit sl,
                       input bit mr, input bit fl, input bit r);
        s_tvalid = sv;
        s_tdata  = d;
        s_tlast  = sl;
        m_tready = mr;
        flush    = fl;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_to_neg();
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        flush    = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
    endtask

    task automatic resync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int exp9;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        flush    = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc(0, '0, 0, 0, 0, 1);

        // Three pushes, held, then drained in order.
        cyc(1, DW'(1), 0, 0, 0, 0);
        cyc(1, DW'(2), 0, 0, 0, 0);
        cyc(1, DW'(3), 1, 0, 0, 0);
        idle_to_neg();
        check("t1_level", 64'(level), 64'd3);
        check_w("t1_head", m_tdata, DW'(1));
        resync();
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1, 0, 0);
        idle_to_neg();
        check("t1_pkt", 64'(pkt_count), 64'd1);
        check("t1_level0", 64'(level), 64'd0);
        resync();

        // Fill to DEPTH, pop once while pushing: push refused in that cycle.
        for (int i = 0; i < DEPTH; i++) cyc(1, rand_data(), 1'($urandom), 0, 0, 0);
        idle_to_neg();
        check("t2_full_rdy", 64'(s_tready), 64'd0);
        check("t2_full_level", 64'(level), 64'(DEPTH));
        resync();
        cyc(1, rand_data(), 0, 1, 0, 0);
        idle_to_neg();
        check("t2_rdy_after_pop", 64'(s_tready), 64'd1);
        check("t2_level_after_pop", 64'(level), 64'(DEPTH - 1));
        resync();
        for (int i = 0; i < DEPTH; i++) cyc(0, '0, 0, 1, 0, 0);

        // Streaming at level 5 across two pointer wraps.
        for (int i = 0; i < 5; i++) cyc(1, rand_data(), 1'($urandom), 0, 0, 0);
        for (int i = 0; i < 40; i++) cyc(1, rand_data(), 1'($urandom), 1, 0, 0);
        idle_to_neg();
        check("t3_level", 64'(level), 64'd5);
        resync();
        for (int i = 0; i < 6; i++) cyc(0, '0, 0, 1, 0, 0);

        // Flush at level 7 with a simultaneous push.
        for (int i = 0; i < 7; i++) cyc(1, rand_data(), 1'($urandom), 0, 0, 0);
        cyc(1, rand_data(), 1, 0, 1, 0);
        idle_to_neg();
        check("t4_level", 64'(level), 64'd0);
        check("t4_tvalid", 64'(m_tvalid), 64'd0);
        resync();
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1, 0, 0);

        // Reset mid-packet, then a fresh two-beat packet.
        for (int i = 0; i < 4; i++) cyc(1, rand_data(), 0, 0, 0, 0);
        cyc(0, '0, 0, 0, 0, 1);
        idle_to_neg();
        check("t5_tvalid", 64'(m_tvalid), 64'd0);
        check("t5_level", 64'(level), 64'd0);
        check("t5_pkt", 64'(pkt_count), 64'd0);
        check("t5_rdy", 64'(s_tready), 64'd1);
        resync();
        cyc(1, rand_data(), 0, 0, 0, 0);
        cyc(1, rand_data(), 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1, 0, 0);
        idle_to_neg();
        check("t5_pkt_after", 64'(pkt_count), 64'd1);
        resync();

        // High-water mark: fill to 9, drain, then flush.
`ifdef CMS_FIFO_STATS_EN
        exp9 = 9;
`else
        exp9 = 0;
`endif
        for (int i = 0; i < 9; i++) cyc(1, rand_data(), 1'($urandom), 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, '0, 0, 1, 0, 0);
        idle_to_neg();
        check("t6_max", 64'(max_level), 64'(exp9));
        resync();
        cyc(0, '0, 0, 0, 1, 0);
        idle_to_neg();
        check("t6_max_flush", 64'(max_level), 64'd0);
        resync();

        // Randomized traffic in phases of differing producer/consumer bias.
        for (int ph = 0; ph < 6; ph++) begin
            int pv;
            int pr;
            pv = 30 + int'($urandom_range(0, 70));
            pr = 20 + int'($urandom_range(0, 80));
            for (int i = 0; i < 400; i++) begin
                cyc(int'($urandom_range(0, 99)) < pv, rand_data(), 1'($urandom),
                    int'($urandom_range(0, 99)) < pr,
                    $urandom_range(0, 120) == 0,
                    $urandom_range(0, 500) == 0);
            end
        end
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, '0, 0, 1, 0, 0);
        idle_to_neg();
        check("final_level", 64'(level), 64'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
